// File: rtl/pulse_conditioner.sv
// Detector-line front end: sync, rising-edge to PULSE_WIDTH-cycle pulse, per-channel dead time, sticky pile-up flags.
// Latency: pulse_out rises SYNC_STAGES+1 edges after pulse_in is first sampled high (+1 with GLITCH_FILTER_EN).
// Backpressure: none; edges arriving during ACTIVE/DEAD are dropped and flagged in pileup.
module pulse_conditioner #(
    parameter int NUM_INPUTS  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_WIDTH = 1,
    parameter int DEAD_TIME   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_INPUTS-1:0] pulse_in,
    input  logic                  enable,
    input  logic [NUM_INPUTS-1:0] mask,
    input  logic                  clear_pileup,
    output logic [NUM_INPUTS-1:0] pulse_out,
    output logic [NUM_INPUTS-1:0] pileup
);

    localparam int WW = $clog2(PULSE_WIDTH + 1);
    localparam int DW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
    localparam logic [WW-1:0] W_ONE  = WW'(1);
    localparam logic [WW-1:0] W_LAST = WW'(PULSE_WIDTH);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_LAST = DW'(DEAD_TIME);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DEAD   = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0][NUM_INPUTS-1:0] sync_q;
    logic [NUM_INPUTS-1:0] prev_q;
    logic [NUM_INPUTS-1:0] sync_last;
    logic [NUM_INPUTS-1:0] rise;
    logic [NUM_INPUTS-1:0] live;

    state_e        state_q [NUM_INPUTS];
    state_e        state_d [NUM_INPUTS];
    logic [WW-1:0] wcnt_q  [NUM_INPUTS];
    logic [WW-1:0] wcnt_d  [NUM_INPUTS];
    logic [DW-1:0] dcnt_q  [NUM_INPUTS];
    logic [DW-1:0] dcnt_d  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] pileup_q;
    logic [NUM_INPUTS-1:0] pileup_d;
    logic [NUM_INPUTS-1:0] pile_set;

    // The sync chain ignores enable/mask so a line held high across release yields no edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign live      = {NUM_INPUTS{enable}} & ~mask;

`ifdef GLITCH_FILTER_EN
    logic [NUM_INPUTS-1:0] prev2_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev2_q <= '0;
        end else begin
            prev2_q <= prev_q;
        end
    end

    // Two consecutive high samples are needed before an edge counts.
    assign rise = sync_last & prev_q & ~prev2_q;
`else
    assign rise = sync_last & ~prev_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                state_q[i] <= IDLE;
                wcnt_q[i]  <= '0;
                dcnt_q[i]  <= '0;
            end
            pileup_q <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                state_q[i] <= state_d[i];
                wcnt_q[i]  <= wcnt_d[i];
                dcnt_q[i]  <= dcnt_d[i];
            end
            pileup_q <= pileup_d;
        end
    end

    always_comb begin
        pile_set = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            state_d[i]  = state_q[i];
            wcnt_d[i]   = wcnt_q[i];
            dcnt_d[i]   = dcnt_q[i];
            pile_set[i] = live[i] & rise[i] & (state_q[i] != IDLE);
            if (!live[i]) begin
                state_d[i] = IDLE;
                wcnt_d[i]  = '0;
                dcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (rise[i]) begin
                            state_d[i] = ACTIVE;
                            wcnt_d[i]  = W_ONE;
                        end
                    end
                    ACTIVE: begin
                        if (wcnt_q[i] == W_LAST) begin
                            wcnt_d[i] = '0;
                            if (DEAD_TIME > 0) begin
                                state_d[i] = DEAD;
                                dcnt_d[i]  = D_ONE;
                            end else begin
                                state_d[i] = IDLE;
                            end
                        end else begin
                            wcnt_d[i] = wcnt_q[i] + W_ONE;
                        end
                    end
                    DEAD: begin
                        if (dcnt_q[i] == D_LAST) begin
                            state_d[i] = IDLE;
                            dcnt_d[i]  = '0;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] + D_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        wcnt_d[i]  = '0;
                        dcnt_d[i]  = '0;
                    end
                endcase
            end
        end
        // A new pile-up event outranks a simultaneous clear.
        pileup_d = pile_set | (pileup_q & ~{NUM_INPUTS{clear_pileup}});
    end

    always_comb begin
        pulse_out = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            pulse_out[i] = (state_q[i] == ACTIVE);
        end
        pileup = pileup_q;
    end

endmodule

// File: tb/tb_pulse_conditioner.sv
// Bench for pulse_conditioner: three parameterisations share stimulus; a cycle-stamped scoreboard checks outputs.
module tb_pulse_conditioner;

`ifdef GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int R = LAT - 1;  // offset from first-high drive cycle to the rise cycle

    typedef struct {
        int         cyc;
        int         dut;
        int         tst;
        logic [7:0] po;
        logic [7:0] pu;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] pulse_in;
    logic       enable;
    logic [7:0] mask;
    logic       clear_pileup;
    logic [7:0] po0, pu0, po1, pu1, po2, pu2;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   d;
    exp_t sb[$];
    exp_t mon_e;

    pulse_conditioner #(.NUM_INPUTS(8), .SYNC_STAGES(2), .PULSE_WIDTH(1), .DEAD_TIME(4)) u0 (
        .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in), .enable(enable), .mask(mask),
        .clear_pileup(clear_pileup), .pulse_out(po0), .pileup(pu0));
    pulse_conditioner #(.NUM_INPUTS(8), .SYNC_STAGES(2), .PULSE_WIDTH(2), .DEAD_TIME(4)) u1 (
        .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in), .enable(enable), .mask(mask),
        .clear_pileup(clear_pileup), .pulse_out(po1), .pileup(pu1));
    pulse_conditioner #(.NUM_INPUTS(8), .SYNC_STAGES(2), .PULSE_WIDTH(8), .DEAD_TIME(4)) u2 (
        .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in), .enable(enable), .mask(mask),
        .clear_pileup(clear_pileup), .pulse_out(po2), .pileup(pu2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_po(input int dut);
        case (dut)
            0:       return po0;
            1:       return po1;
            default: return po2;
        endcase
    endfunction

    function automatic logic [7:0] get_pu(input int dut);
        case (dut)
            0:       return pu0;
            1:       return pu1;
            default: return pu2;
        endcase
    endfunction

    task automatic push(input int tst, input int dut, input int c, input logic [7:0] po, input logic [7:0] pu);
        exp_t e;
        e.cyc = c; e.dut = dut; e.tst = tst; e.po = po; e.pu = pu;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            chk($sformatf("t%0d_u%0d_c%0d_pulse_out", mon_e.tst, mon_e.dut, mon_e.cyc), get_po(mon_e.dut), mon_e.po);
            chk($sformatf("t%0d_u%0d_c%0d_pileup", mon_e.tst, mon_e.dut, mon_e.cyc), get_pu(mon_e.dut), mon_e.pu);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; pulse_in = '0; enable = 1'b1; mask = '0; clear_pileup = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int u = 0; u < 3; u++) push(0, u, cyc + k, 8'h00, 8'h00);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic run(input int ch, input logic [31:0] pat, input logic [31:0] clr,
                       input logic [31:0] msk, input int n);
        for (int t = 0; t < n; t++) begin
            pulse_in[ch] = pat[t];
            clear_pileup = clr[t];
            mask[ch]     = msk[t];
            tick();
        end
        pulse_in[ch] = 1'b0; clear_pileup = 1'b0; mask[ch] = 1'b0;
    endtask

    initial begin
        logic [31:0] clr;
        reset_n = 1'b0; pulse_in = '0; enable = 1'b1; mask = '0; clear_pileup = 1'b0;
        do_reset();
        idle(2);

        // t1: latency, single-cycle pulse on ch0 only
        d = cyc;
        for (int rel = 0; rel < R + 8; rel++)
            push(1, 0, d + rel, (rel == R + 1) ? 8'h01 : 8'h00, 8'h00);
        run(0, 32'hFFFF_FFFF, 32'h0, 32'h0, R + 8);
        idle(8);

        // t2: dead time on u1 ch3, rises at r, r+3 (dropped), r+7
        do_reset();
        idle(2);
        d = cyc;
        for (int rel = 0; rel < R + 12; rel++)
            push(2, 1, d + rel,
                 (rel == R + 1 || rel == R + 2 || rel == R + 8 || rel == R + 9) ? 8'h08 : 8'h00,
                 (rel >= R + 4) ? 8'h08 : 8'h00);
        run(3, 32'h0000_019B, 32'h0, 32'h0, R + 12);
        idle(10);

        // t3: clear alone, then clear colliding with a pile-up set, then clear alone
        d = cyc;
        clr = 32'd1 | (32'd1 << (R + 3)) | (32'd1 << (R + 4));
        for (int rel = 0; rel < R + 10; rel++)
            push(3, 1, d + rel,
                 (rel == R + 1 || rel == R + 2) ? 8'h08 : 8'h00,
                 (rel == 0 || rel == R + 4) ? 8'h08 : 8'h00);
        run(3, 32'h0000_001B, clr, 32'h0, R + 10);
        idle(8);

        // t4: mask mid-pulse on u2 ch5, input held high through release
        do_reset();
        idle(2);
        d = cyc;
        for (int rel = 0; rel < R + 20; rel++)
            push(4, 2, d + rel, (rel >= R + 1 && rel <= R + 3) ? 8'h20 : 8'h00, 8'h00);
        run(5, 32'hFFFF_FFFF, 32'h0, 32'h7 << (R + 3), R + 20);
        idle(8);

        // t5: all channels together, then a one-cycle enable drop
        do_reset();
        idle(2);
        d = cyc;
        for (int rel = 0; rel < R + 12; rel++) begin
            push(5, 0, d + rel, (rel == R + 1) ? 8'hFF : 8'h00, 8'h00);
            push(5, 1, d + rel, (rel == R + 1 || rel == R + 2) ? 8'hFF : 8'h00, 8'h00);
        end
        for (int t = 0; t < R + 12; t++) begin
            pulse_in = 8'hFF;
            enable   = (t != R + 4);
            tick();
        end
        pulse_in = '0; enable = 1'b1;
        idle(8);

        // t6: spacing on u0 ch1, gap of 6 accepted, gap of 5 dropped
        do_reset();
        idle(2);
        d = cyc;
        for (int rel = 0; rel < R + 16; rel++)
            push(6, 0, d + rel, (rel == R + 1 || rel == R + 7) ? 8'h02 : 8'h00,
                 (rel >= R + 12) ? 8'h02 : 8'h00);
        run(1, 32'h0000_18C3, 32'h0, 32'h0, R + 16);
        idle(8);

`ifdef GLITCH_FILTER_EN
        // t7: single-sample high ignored, two-sample high accepted
        do_reset();
        idle(2);
        d = cyc;
        for (int rel = 0; rel < R + 12; rel++)
            push(7, 0, d + rel, (rel == R + 7) ? 8'h04 : 8'h00, 8'h00);
        run(2, 32'h0000_00C1, 32'h0, 32'h0, R + 12);
        idle(8);
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("scoreboard_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
